// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch stage: PC, i-memory read handshake, IF/ID register
//
// Purpose:
//   Owns the word-addressed PC, issues one read at a time to instruction
//   memory and fills the IF/ID pipeline register. Obeys hazard-unit
//   stall/flush/write-enable controls and takes redirect targets. A
//   one-entry buffer keeps a word that returns while IF/ID is held.
//
// Ports:
//   clk             in   clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   pc_write        in   0 holds the PC
//   ir_write        in   0 holds IF/ID
//   stall_IFID      in   1 holds IF/ID
//   flush_IFID      in   1 loads a bubble into IF/ID
//   redirect_valid  in   restart fetch at redirect_pc
//   redirect_pc     in   redirect target
//   i_readM         out  instruction memory read request
//   i_address       out  read address (stable until handshake)
//   i_data          in   read data, valid with i_ready
//   i_ready         in   read done; handshake = i_readM & i_ready at an edge
//   instr_ID        out  IF/ID instruction
//   pc_ID           out  IF/ID instruction address
//   pc_plus1_ID     out  IF/ID pc_ID + 1
//   valid_ID        out  IF/ID holds a real instruction

module instruction_fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pc_write,
  input  logic                 ir_write,
  input  logic                 stall_IFID,
  input  logic                 flush_IFID,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] instr_ID,
  output logic [WORD_SIZE-1:0] pc_ID,
  output logic [WORD_SIZE-1:0] pc_plus1_ID,
  output logic                 valid_ID
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic                 r_run;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_pend_pc;
  logic [WORD_SIZE-1:0] r_buf;
  logic [WORD_SIZE-1:0] r_instr_id;
  logic [WORD_SIZE-1:0] r_pc_id;
  logic [WORD_SIZE-1:0] r_pc_plus1_id;
  logic                 r_valid_id;

  logic                 w_hold;
  logic                 w_req;
  logic                 w_hs;
  logic [WORD_SIZE-1:0] w_pc_plus1;

  assign w_hold     = stall_IFID | ~ir_write | ~pc_write;
  // r_run keeps the request off for the first cycle after reset release,
  // so the first valid IF/ID entry lands on the second edge and a stale
  // i_ready in that first cycle cannot be taken as a handshake.
  assign w_req      = r_run & ((r_state == S_FETCH) | (r_state == S_DRAIN));
  assign w_hs       = w_req & i_ready;
  assign w_pc_plus1 = r_pc + ONE;

  assign i_readM     = w_req;
  assign i_address   = r_pc;
  assign instr_ID    = r_instr_id;
  assign pc_ID       = r_pc_id;
  assign pc_plus1_ID = r_pc_plus1_id;
  assign valid_ID    = r_valid_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FETCH;
      r_run         <= 1'b0;
      r_pc          <= RESET_PC;
      r_pend_pc     <= '0;
      r_buf         <= '0;
      r_instr_id    <= '0;
      r_pc_id       <= '0;
      r_pc_plus1_id <= '0;
      r_valid_id    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (redirect_valid) begin
            r_valid_id <= 1'b0;
            // An issued request cannot be aborted: wait it out in DRAIN.
            if (w_hs || !w_req) begin
              r_pc <= redirect_pc;
            end else begin
              r_pend_pc <= redirect_pc;
              r_state   <= S_DRAIN;
            end
          end else if (flush_IFID) begin
            // Bubble; any returning word is dropped and refetched from r_pc.
            r_valid_id <= 1'b0;
          end else if (w_hold) begin
            if (w_hs) begin
              r_buf   <= i_data;
              r_state <= S_HOLD;
            end
          end else if (w_hs) begin
            r_instr_id    <= i_data;
            r_pc_id       <= r_pc;
            r_pc_plus1_id <= w_pc_plus1;
            r_valid_id    <= 1'b1;
            r_pc          <= w_pc_plus1;
          end else begin
            r_valid_id <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            r_valid_id <= 1'b0;
            r_pc       <= redirect_pc;
            r_state    <= S_FETCH;
          end else if (flush_IFID) begin
            // Buffered word is discarded; r_pc still points at it.
            r_valid_id <= 1'b0;
            r_state    <= S_FETCH;
          end else if (!w_hold) begin
            r_instr_id    <= r_buf;
            r_pc_id       <= r_pc;
            r_pc_plus1_id <= w_pc_plus1;
            r_valid_id    <= 1'b1;
            r_pc          <= w_pc_plus1;
            r_state       <= S_FETCH;
          end
        end

        S_DRAIN: begin
          r_valid_id <= 1'b0;
          if (w_hs) begin
            r_pc    <= redirect_valid ? redirect_pc : r_pend_pc;
            r_state <= S_FETCH;
          end else if (redirect_valid) begin
            r_pend_pc <= redirect_pc;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        pc_write;
  logic        ir_write;
  logic        stall_IFID;
  logic        flush_IFID;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        i_ready;

  logic        i_readM,     i_readM_w;
  logic [15:0] i_address,   i_address_w;
  logic [15:0] i_data,      i_data_w;
  logic [15:0] instr_ID,    instr_ID_w;
  logic [15:0] pc_ID,       pc_ID_w;
  logic [15:0] pc_plus1_ID, pc_plus1_ID_w;
  logic        valid_ID,    valid_ID_w;

  int vectors;
  int miscompares;
  int rd5_cnt;
  logic [15:0] sb[$];
  logic [15:0] sb_w[$];
  logic [15:0] e;
  logic [15:0] exp_addr;

  instruction_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write), .ir_write(ir_write),
    .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .instr_ID(instr_ID), .pc_ID(pc_ID), .pc_plus1_ID(pc_plus1_ID), .valid_ID(valid_ID)
  );

  instruction_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write), .ir_write(ir_write),
    .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .i_readM(i_readM_w), .i_address(i_address_w), .i_data(i_data_w), .i_ready(i_ready),
    .instr_ID(instr_ID_w), .pc_ID(pc_ID_w), .pc_plus1_ID(pc_plus1_ID_w), .valid_ID(valid_ID_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word k holds 16'h1000 + k.
  always_comb begin
    i_data   = 16'h1000 + i_address;
    i_data_w = 16'h1000 + i_address_w;
  end

  always @(posedge clk) begin
    if (reset_n && i_readM && i_ready && i_address == 16'd5) rd5_cnt <= rd5_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pc_write = 1'b1; ir_write = 1'b1; stall_IFID = 1'b0;
    flush_IFID = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; i_ready = 1'b1;
    #12;
    vectors++;
    if (i_readM !== 1'b0 || valid_ID !== 1'b0 || instr_ID !== 16'h0 || pc_ID !== 16'h0 || pc_plus1_ID !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: readM=%b valid=%b instr=%h pc=%h pc1=%h, want 0 0 0000 0000 0000",
               i_readM, valid_ID, instr_ID, pc_ID, pc_plus1_ID);
    end
    tick();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    tick();
    vectors++;
    if (valid_ID !== 1'b0 || i_readM !== 1'b1 || i_address !== 16'h0000) begin
      miscompares++;
      $display("FAIL seq_first_edge: valid=%b readM=%b addr=%h, want 0 1 0000", valid_ID, i_readM, i_address);
    end
    for (int k = 0; k < 4; k++) sb.push_back(16'(k));
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (valid_ID !== 1'b1 || sb.size() == 0) begin
        miscompares++;
        $display("FAIL seq_valid: valid=%b queued=%0d, want 1 with entry queued", valid_ID, sb.size());
      end else begin
        e = sb.pop_front();
        if (instr_ID !== 16'h1000 + e || pc_ID !== e || pc_plus1_ID !== e + 16'd1) begin
          miscompares++;
          $display("FAIL seq_ifid: instr=%h pc=%h pc1=%h, want %h %h %h",
                   instr_ID, pc_ID, pc_plus1_ID, 16'h1000 + e, e, e + 16'd1);
        end
      end
    end
  endtask

  task automatic test_stall();
    sb.push_back(16'd4);
    tick();
    vectors++;
    if (valid_ID !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL stall_pre: valid=%b, want 1", valid_ID);
    end else begin
      e = sb.pop_front();
      if (instr_ID !== 16'h1000 + e || pc_ID !== e) begin
        miscompares++;
        $display("FAIL stall_pre_ifid: instr=%h pc=%h, want %h %h", instr_ID, pc_ID, 16'h1000 + e, e);
      end
    end
    stall_IFID = 1'b1; ir_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (valid_ID !== 1'b1 || pc_ID !== 16'd4 || instr_ID !== 16'h1004 || i_readM !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h readM=%b, want 1 0004 1004 0",
                 k, valid_ID, pc_ID, instr_ID, i_readM);
      end
    end
    stall_IFID = 1'b0; ir_write = 1'b1;
    sb.push_back(16'd5);
    tick();
    vectors++;
    if (valid_ID !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL stall_release: valid=%b, want 1", valid_ID);
    end else begin
      e = sb.pop_front();
      if (instr_ID !== 16'h1000 + e || pc_ID !== e || pc_plus1_ID !== e + 16'd1) begin
        miscompares++;
        $display("FAIL stall_release_ifid: instr=%h pc=%h pc1=%h, want %h %h %h",
                 instr_ID, pc_ID, pc_plus1_ID, 16'h1000 + e, e, e + 16'd1);
      end
    end
    vectors++;
    if (i_address !== 16'd6 || rd5_cnt !== 1) begin
      miscompares++;
      $display("FAIL stall_no_refetch: addr=%h reads_of_5=%0d, want 0006 1", i_address, rd5_cnt);
    end
  endtask

  task automatic test_wait_states();
    exp_addr = 16'd6;
    for (int c = 0; c < 9; c++) begin
      i_ready = (c % 3 == 2);
      vectors++;
      if (i_readM !== 1'b1 || i_address !== exp_addr) begin
        miscompares++;
        $display("FAIL wait_addr[%0d]: readM=%b addr=%h, want 1 %h", c, i_readM, i_address, exp_addr);
      end
      if (i_ready) sb.push_back(exp_addr);
      tick();
      vectors++;
      if (c % 3 == 2) begin
        exp_addr = exp_addr + 16'd1;
        if (valid_ID !== 1'b1 || sb.size() == 0) begin
          miscompares++;
          $display("FAIL wait_valid[%0d]: valid=%b, want 1", c, valid_ID);
        end else begin
          e = sb.pop_front();
          if (instr_ID !== 16'h1000 + e || pc_ID !== e) begin
            miscompares++;
            $display("FAIL wait_ifid[%0d]: instr=%h pc=%h, want %h %h", c, instr_ID, pc_ID, 16'h1000 + e, e);
          end
        end
      end else if (valid_ID !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_gap[%0d]: valid=%b, want 0", c, valid_ID);
      end
    end
    i_ready = 1'b1;
  endtask

  task automatic test_redirect_ready();
    redirect_valid = 1'b1; redirect_pc = 16'h0040; flush_IFID = 1'b1;
    tick();
    redirect_valid = 1'b0; flush_IFID = 1'b0;
    vectors++;
    if (valid_ID !== 1'b0 || i_readM !== 1'b1 || i_address !== 16'h0040) begin
      miscompares++;
      $display("FAIL redir_ready: valid=%b readM=%b addr=%h, want 0 1 0040", valid_ID, i_readM, i_address);
    end
    sb.push_back(16'h0040);
    sb.push_back(16'h0041);
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (valid_ID !== 1'b1 || sb.size() == 0) begin
        miscompares++;
        $display("FAIL redir_ready_valid[%0d]: valid=%b, want 1", k, valid_ID);
      end else begin
        e = sb.pop_front();
        if (instr_ID !== 16'h1000 + e || pc_ID !== e || pc_plus1_ID !== e + 16'd1) begin
          miscompares++;
          $display("FAIL redir_ready_ifid[%0d]: instr=%h pc=%h pc1=%h, want %h %h %h",
                   k, instr_ID, pc_ID, pc_plus1_ID, 16'h1000 + e, e, e + 16'd1);
        end
      end
    end
  endtask

  task automatic test_redirect_drain();
    i_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (i_readM !== 1'b1 || i_address !== 16'h0042) begin
        miscompares++;
        $display("FAIL drain_addr[%0d]: readM=%b addr=%h, want 1 0042", k, i_readM, i_address);
      end
      tick();
      vectors++;
      if (valid_ID !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_bubble[%0d]: valid=%b, want 0", k, valid_ID);
      end
    end
    i_ready = 1'b1;
    tick();
    vectors++;
    if (valid_ID !== 1'b0 || i_readM !== 1'b1 || i_address !== 16'h0080) begin
      miscompares++;
      $display("FAIL drain_done: valid=%b readM=%b addr=%h, want 0 1 0080", valid_ID, i_readM, i_address);
    end
    sb.push_back(16'h0080);
    tick();
    vectors++;
    if (valid_ID !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL drain_next_valid: valid=%b, want 1", valid_ID);
    end else begin
      e = sb.pop_front();
      if (instr_ID !== 16'h1000 + e || pc_ID !== e) begin
        miscompares++;
        $display("FAIL drain_next_ifid: instr=%h pc=%h, want %h %h", instr_ID, pc_ID, 16'h1000 + e, e);
      end
    end
  endtask

  task automatic test_wrap_reset();
    i_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (i_readM !== 1'b0 || valid_ID !== 1'b0 || pc_ID !== 16'h0 || i_readM_w !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_drain: readM=%b valid=%b pc=%h readM_w=%b, want 0 0 0000 0",
               i_readM, valid_ID, pc_ID, i_readM_w);
    end
    i_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(16'h0000);
    sb.push_back(16'h0001);
    sb_w.push_back(16'hFFFF);
    sb_w.push_back(16'h0000);
    tick();
    vectors++;
    if (valid_ID !== 1'b0 || i_address !== 16'h0000 || i_address_w !== 16'hFFFF || i_readM !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_first: valid=%b addr=%h addr_w=%h readM=%b, want 0 0000 ffff 1",
               valid_ID, i_address, i_address_w, i_readM);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (valid_ID !== 1'b1 || sb.size() == 0) begin
        miscompares++;
        $display("FAIL restart_valid[%0d]: valid=%b, want 1", k, valid_ID);
      end else begin
        e = sb.pop_front();
        if (instr_ID !== 16'h1000 + e || pc_ID !== e) begin
          miscompares++;
          $display("FAIL restart_ifid[%0d]: instr=%h pc=%h, want %h %h", k, instr_ID, pc_ID, 16'h1000 + e, e);
        end
      end
      vectors++;
      if (valid_ID_w !== 1'b1 || sb_w.size() == 0) begin
        miscompares++;
        $display("FAIL wrap_valid[%0d]: valid=%b, want 1", k, valid_ID_w);
      end else begin
        e = sb_w.pop_front();
        if (instr_ID_w !== 16'h1000 + e || pc_ID_w !== e || pc_plus1_ID_w !== e + 16'd1) begin
          miscompares++;
          $display("FAIL wrap_ifid[%0d]: instr=%h pc=%h pc1=%h, want %h %h %h",
                   k, instr_ID_w, pc_ID_w, pc_plus1_ID_w, 16'h1000 + e, e, e + 16'd1);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rd5_cnt = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_wait_states();
    test_redirect_ready();
    test_redirect_drain();
    test_wrap_reset();
    vectors++;
    if (sb.size() != 0 || sb_w.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drained: left=%0d left_w=%0d, want 0 0", sb.size(), sb_w.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
